t05_detranslation: RTL and testbench

Huffman bitstream decoder for the team_05 compression datapath. It consumes the serial stream that the encoder's translation stage produces: a 32-bit total-character count sent MSB first, then one root-to-leaf path per character. It walks the Huffman tree held in an external node memory and emits one decoded byte per leaf to the downstream writer.

---
 rtl/t05_detranslation.sv | 189 ++++++++++++++++++
 tb/tb_t05_detranslation.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/t05_detranslation.sv
// Huffman bitstream decoder: reads a 32-bit character count, then walks the tree per path bit and emits one byte per leaf.
// Optional EOF_STOP_EN: a leaf carrying 8'h1A terminates the decode instead of being emitted.
module t05_detranslation #(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned ROOT_ADDR    = 0,
    parameter int unsigned MAX_DEPTH    = 128,
    parameter logic [3:0]  ACTIVE_STATE = 4'd6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        en_state,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic [ADDR_W-1:0] node_addr,
    output logic              node_req,
    input  logic              node_ack,
    input  logic              node_leaf,
    input  logic [7:0]        node_char,
    input  logic [ADDR_W-1:0] node_left,
    input  logic [ADDR_W-1:0] node_right,
    output logic [7:0]        char_out,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [31:0]       tot_char,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W    = 32;
    localparam int unsigned DEPTH_W  = 8;
    localparam int unsigned BITCNT_W = 6;
    localparam logic [ADDR_W-1:0]   ROOT      = ADDR_W'(ROOT_ADDR);
    localparam logic [DEPTH_W-1:0]  DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
    localparam logic [BITCNT_W-1:0] LAST_BIT  = BITCNT_W'(CNT_W - 1);
`ifdef EOF_STOP_EN
    localparam logic [7:0] EOF_CHAR = 8'h1A;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_CNT, S_FETCH, S_BIT, S_EMIT, S_DONE, S_ERR
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    tot_char_n, char_cnt, char_cnt_n;
    logic [7:0]          char_out_n;
    logic [ADDR_W-1:0]   node_addr_n, left_q, left_n, right_q, right_n;
    logic [BITCNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [DEPTH_W-1:0]  depth, depth_n;
    logic                done_n, err_n;

    logic             active;
    logic [CNT_W-1:0] tot_shift;
    logic [CNT_W-1:0] char_cnt_inc;

    assign active       = (en_state == ACTIVE_STATE);
    assign tot_shift    = {tot_char[CNT_W-2:0], bit_in};
    assign char_cnt_inc = char_cnt + CNT_W'(1);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tot_char  <= '0;
            char_out  <= '0;
            node_addr <= ROOT;
            left_q    <= '0;
            right_q   <= '0;
            char_cnt  <= '0;
            bit_cnt   <= '0;
            depth     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            tot_char  <= tot_char_n;
            char_out  <= char_out_n;
            node_addr <= node_addr_n;
            left_q    <= left_n;
            right_q   <= right_n;
            char_cnt  <= char_cnt_n;
            bit_cnt   <= bit_cnt_n;
            depth     <= depth_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    // Next-state and handshake logic; nothing advances outside the active top-level state
    always_comb begin
        state_n     = state;
        tot_char_n  = tot_char;
        char_out_n  = char_out;
        node_addr_n = node_addr;
        left_n      = left_q;
        right_n     = right_q;
        char_cnt_n  = char_cnt;
        bit_cnt_n   = bit_cnt;
        depth_n     = depth;
        bit_ready   = 1'b0;
        node_req    = 1'b0;
        char_valid  = 1'b0;

        case (state)
            S_IDLE: begin
                if (active) begin
                    char_cnt_n = '0;
                    bit_cnt_n  = '0;
                    depth_n    = '0;
                    state_n    = S_LOAD_CNT;
                end
            end
            S_LOAD_CNT: begin
                bit_ready = active;
                if (active && bit_valid) begin
                    tot_char_n = tot_shift;
                    bit_cnt_n  = bit_cnt + BITCNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
                        if (tot_shift == '0) begin
                            state_n = S_DONE;
                        end else begin
                            node_addr_n = ROOT;
                            state_n     = S_FETCH;
                        end
                    end
                end
            end
            S_FETCH: begin
                node_req = active;
                if (active && node_ack) begin
                    if (node_leaf) begin
`ifdef EOF_STOP_EN
                        if (node_char == EOF_CHAR) begin
                            state_n = S_DONE;
                        end else begin
                            char_out_n = node_char;
                            state_n    = S_EMIT;
                        end
`else
                        char_out_n = node_char;
                        state_n    = S_EMIT;
`endif
                    end else begin
                        left_n  = node_left;
                        right_n = node_right;
                        state_n = S_BIT;
                    end
                end
            end
            S_BIT: begin
                bit_ready = active;
                if (active && bit_valid) begin
                    if (depth == DEPTH_MAX) begin
                        state_n = S_ERR;
                    end else begin
                        node_addr_n = bit_in ? right_q : left_q;
                        depth_n     = depth + DEPTH_W'(1);
                        state_n     = S_FETCH;
                    end
                end
            end
            S_EMIT: begin
                char_valid = active;
                if (active && char_ready) begin
                    char_cnt_n = char_cnt_inc;
                    depth_n    = '0;
                    if (char_cnt_inc == tot_char) begin
                        state_n = S_DONE;
                    end else begin
                        node_addr_n = ROOT;
                        state_n     = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                if (!active) state_n = S_IDLE;
            end
            S_ERR: begin
                if (!active) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        done_n = (state_n == S_DONE);
        err_n  = (state_n == S_ERR);
    end

endmodule

// File: tb/tb_t05_detranslation.sv
// Directed bench for t05_detranslation: node memory model, scoreboard of expected characters.
module tb_t05_detranslation;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned NODES  = 512;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        en_state;
    logic              bit_in, bit_valid, bit_ready;
    logic [ADDR_W-1:0] node_addr;
    logic              node_req, node_ack;
    logic              node_leaf;
    logic [7:0]        node_char;
    logic [ADDR_W-1:0] node_left, node_right;
    logic [7:0]        char_out;
    logic              char_valid, char_ready;
    logic [31:0]       tot_char;
    logic              done, err;

    logic              mem_leaf  [NODES];
    logic [7:0]        mem_char  [NODES];
    logic [ADDR_W-1:0] mem_left  [NODES];
    logic [ADDR_W-1:0] mem_right [NODES];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          req_seen = 0;
    int          cv_seen  = 0;
    logic [7:0]  exp_q [$];

    t05_detranslation #(.MAX_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .en_state(en_state),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .node_addr(node_addr), .node_req(node_req), .node_ack(node_ack),
        .node_leaf(node_leaf), .node_char(node_char),
        .node_left(node_left), .node_right(node_right),
        .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
        .tot_char(tot_char), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Node memory: data follows the address, ack one cycle after a request
    assign node_leaf  = mem_leaf[node_addr];
    assign node_char  = mem_char[node_addr];
    assign node_left  = mem_left[node_addr];
    assign node_right = mem_right[node_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) node_ack <= 1'b0;
        else     node_ack <= node_req && !node_ack;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge (scoreboard pop on char handshake), return 1 after posedge
    task automatic tick(output logic br);
        @(negedge clk);
        br = bit_ready;
        if (node_req)   req_seen++;
        if (char_valid) cv_seen++;
        if (char_valid && char_ready) begin
            if (exp_q.size() == 0) check("unexpected_char", 32'(char_out), 32'hFFFF_FFFF);
            else                   check("char_out", 32'(char_out), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        logic br;
        tick(br);
    endtask

    task automatic send_bit(input logic b);
        logic br;
        int   n;
        bit_in    = b;
        bit_valid = 1'b1;
        n = 0;
        do begin
            tick(br);
            n++;
        end while (!br && n < 200);
        if (!br) check("bit_accept_timeout", 32'(br), 32'd1);
        bit_valid = 1'b0;
    endtask

    task automatic send_count(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic restart();
        en_state = 4'd0;
        step();
        check("idle_done", 32'(done), 32'd0);
        check("idle_err", 32'(err), 32'd0);
        en_state = 4'd6;
        step();
    endtask

    task automatic clear_tree();
        for (int i = 0; i < int'(NODES); i++) begin
            mem_leaf[i]  = 1'b0;
            mem_char[i]  = 8'h00;
            mem_left[i]  = '0;
            mem_right[i] = '0;
        end
    endtask

    task automatic set_node(input int a, input logic leaf, input logic [7:0] c,
                            input int l, input int r);
        mem_leaf[a]  = leaf;
        mem_char[a]  = c;
        mem_left[a]  = ADDR_W'(l);
        mem_right[a] = ADDR_W'(r);
    endtask

    task automatic abc_tree();
        clear_tree();
        set_node(0, 1'b0, 8'h00, 1, 2);
        set_node(1, 1'b1, "A",   0, 0);
        set_node(2, 1'b0, 8'h00, 3, 4);
        set_node(3, 1'b1, "B",   0, 0);
        set_node(4, 1'b1, "C",   0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] held_addr;
        int req0, cv0, n;

        rst        = 1'b1;
        en_state   = 4'd6;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        char_ready = 1'b1;
        abc_tree();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_tot_char", tot_char, 32'd0);
        check("rst_char_out", 32'(char_out), 32'd0);
        check("rst_node_addr", 32'(node_addr), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_handshakes", {29'd0, bit_ready, node_req, char_valid}, 32'd0);

        // Count 3, path bits 0 / 1 0 / 1 1
        exp_q.push_back("A"); exp_q.push_back("B"); exp_q.push_back("C");
        send_count(32'd3);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        wait_done(50);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t1_tot_char", tot_char, 32'd3);
        bit_valid = 1'b1;
        step();
        check("t1_done_bit_ready", 32'(bit_ready), 32'd0);
        check("t1_done_held", 32'(done), 32'd1);
        bit_valid = 1'b0;
        restart();
        check("t1_tot_char_retained", tot_char, 32'd3);

        // Zero count: done straight after the count, no fetch, no emit
        req0 = req_seen;
        cv0  = cv_seen;
        send_count(32'd0);
        check("t2_done_now", 32'(done), 32'd1);
        check("t2_tot_char", tot_char, 32'd0);
        check("t2_bit_ready", 32'(bit_ready), 32'd0);
        repeat (3) step();
        check("t2_no_node_req", 32'(req_seen - req0), 32'd0);
        check("t2_no_char_valid", 32'(cv_seen - cv0), 32'd0);
        restart();

        // Downstream stall during the first emit
        char_ready = 1'b0;
        exp_q.push_back("A"); exp_q.push_back("B"); exp_q.push_back("C");
        send_count(32'd3);
        send_bit(1'b0);
        n = 0;
        while (!char_valid && n < 20) begin step(); n++; end
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t3_stall_valid", 32'(char_valid), 32'd1);
            check("t3_stall_char", 32'(char_out), 32'h41);
            check("t3_stall_no_bit", 32'(bit_ready), 32'd0);
            step();
        end
        bit_valid  = 1'b0;
        char_ready = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        wait_done(50);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        restart();

        // Gate the block away mid-path, then resume
        exp_q.push_back("A"); exp_q.push_back("B"); exp_q.push_back("C");
        send_count(32'd3);
        send_bit(1'b0); send_bit(1'b1);
        held_addr = node_addr;
        en_state  = 4'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_gated_handshakes", {29'd0, bit_ready, node_req, char_valid}, 32'd0);
            check("t4_gated_addr", 32'(node_addr), 32'(held_addr));
            check("t4_gated_done", 32'(done), 32'd0);
        end
        en_state = 4'd6;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        wait_done(50);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        restart();

        // Self-loop tree overruns MAX_DEPTH=2 on the third bit
        clear_tree();
        set_node(0, 1'b0, 8'h00, 0, 0);
        send_count(32'd1);
        send_bit(1'b1); send_bit(1'b1);
        check("t5_err_before", 32'(err), 32'd0);
        send_bit(1'b1);
        check("t5_err", 32'(err), 32'd1);
        check("t5_done", 32'(done), 32'd0);
        step();
        check("t5_err_idle_hs", {29'd0, bit_ready, node_req, char_valid}, 32'd0);
        restart();

        // EOF marker leaf
        clear_tree();
        set_node(0, 1'b0, 8'h00, 1, 5);
        set_node(1, 1'b1, "A",   0, 0);
        set_node(5, 1'b1, 8'h1A, 0, 0);
        exp_q.push_back("A");
`ifndef EOF_STOP_EN
        exp_q.push_back(8'h1A);
`endif
        send_count(32'd5);
        send_bit(1'b0); send_bit(1'b1);
`ifdef EOF_STOP_EN
        wait_done(50);
`else
        repeat (10) step();
        check("t6_not_done", 32'(done), 32'd0);
        check("t6_waiting_bits", 32'(bit_ready), 32'd1);
`endif
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        en_state = 4'd0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
